// File: rtl/cpu_types_pkg.sv
// Shared CPU types: op encodings and FSM states
// for the iterative multiply/divide unit.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    MDU_MULTU,
    MDU_MULT,
    MDU_DIVU,
    MDU_DIV
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIXUP,
    DONE
  } mdu_state_t;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO,
// one shift-add or restoring step per cycle.
module mult_div_unit
  import cpu_types_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  mdu_op_t          op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_t         state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   dsr;
  mdu_op_t            op_q;
  logic               neg_a;
  logic               neg_b;

  logic               sa;
  logic               sb;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     madd;
  logic [2*WIDTH-1:0] mul_nxt;
  logic [WIDTH:0]     rsh;
  logic [WIDTH:0]     dsub;
  logic [2*WIDTH-1:0] div_nxt;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  assign sa    = op[0] & opa[WIDTH-1];
  assign sb    = op[0] & opb[WIDTH-1];
  assign mag_a = sa ? -opa : opa;
  assign mag_b = sb ? -opb : opb;

  // dsr holds |a| for mult, |b| for div
  assign madd = {1'b0, acc[2*WIDTH-1:WIDTH]}
              + {1'b0, (acc[0] ? dsr : '0)};
  assign mul_nxt = {madd, acc[WIDTH-1:1]};

  assign rsh  = acc[2*WIDTH-1:WIDTH-1];
  assign dsub = rsh - {1'b0, dsr};
  assign div_nxt = dsub[WIDTH]
    ? {rsh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
    : {dsub[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  always_comb begin
    prod   = acc;
    fix_hi = acc[2*WIDTH-1:WIDTH];
    fix_lo = acc[WIDTH-1:0];
    if (op_q[1]) begin
      if (op_q == MDU_DIV && (neg_a ^ neg_b))
        fix_lo = -acc[WIDTH-1:0];
      if (op_q == MDU_DIV && neg_a)
        fix_hi = -acc[2*WIDTH-1:WIDTH];
    end else begin
      if (op_q == MDU_MULT && (neg_a ^ neg_b))
        prod = -acc;
      fix_hi = prod[2*WIDTH-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      dsr      <= '0;
      op_q     <= MDU_MULTU;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            op_q     <= op;
            neg_a    <= sa;
            neg_b    <= sb;
            cnt      <= '0;
            div_zero <= 1'b0;
            if (op[1] && opb == '0) begin
              hi       <= opa;
              lo       <= '1;
              div_zero <= 1'b1;
              state    <= DONE;
            end else begin
              dsr   <= op[1] ? mag_b : mag_a;
              acc   <= {{WIDTH{1'b0}},
                        (op[1] ? mag_a : mag_b)};
              state <= CALC;
            end
          end else begin
            if (hi_we) hi <= opa;
            if (lo_we) lo <= opa;
          end
        end
        CALC: begin
          acc <= op_q[1] ? div_nxt : mul_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1))
            state <= FIXUP;
        end
        FIXUP: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected
// results queued at issue, compared on done.
module tb_mult_div_unit;
  import cpu_types_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
  } exp_t;

  logic         clk = 0;
  logic         rst;
  logic         start;
  mdu_op_t      op;
  logic [W-1:0] opa;
  logic [W-1:0] opb;
  logic         hi_we;
  logic         lo_we;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int   n_chk = 0;
  int   n_err = 0;
  exp_t sb[$];

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .op(op), .opa(opa), .opb(opb),
    .hi_we(hi_we), .lo_we(lo_we),
    .busy(busy), .done(done),
    .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h",
               tag, got, want);
    end
  endtask

  function automatic exp_t model(mdu_op_t o,
                                 logic [W-1:0] a,
                                 logic [W-1:0] b);
    exp_t e;
    logic [63:0] p;
    e.dz  = 1'b0;
    e.lat = W + 2;
    case (o)
      MDU_MULTU: p = {32'd0, a} * {32'd0, b};
      MDU_MULT:  p = $signed({{32{a[W-1]}}, a})
                   * $signed({{32{b[W-1]}}, b});
      default:   p = '0;
    endcase
    e.hi = p[63:32];
    e.lo = p[31:0];
    if (o[1]) begin
      if (b == 0) begin
        e.hi = a; e.lo = '1; e.dz = 1'b1; e.lat = 1;
      end else if (o == MDU_DIVU) begin
        e.lo = a / b; e.hi = a % b;
      end else if (a == 32'h8000_0000 && b == '1) begin
        e.lo = a; e.hi = '0;
      end else begin
        e.lo = $signed(a) / $signed(b);
        e.hi = $signed(a) % $signed(b);
      end
    end
    return e;
  endfunction

  task automatic run_op(input string tag,
                        input mdu_op_t o,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input exp_t e,
                        input bit disturb);
    exp_t x;
    int   cyc;
    start = 1; op = o; opa = a; opb = b;
    sb.push_back(e);
    @(negedge clk);
    start = 0;
    cyc = 1;
    while (!done && cyc < 100) begin
      if (disturb && cyc == 5) begin
        start = 1; op = MDU_MULTU;
        opa = 32'hDEAD; opb = 32'h3; hi_we = 1;
      end else begin
        start = 0; hi_we = 0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 0; hi_we = 0;
    x = sb.pop_front();
    chk({tag, " done"}, 64'(done), 64'd1);
    chk({tag, " lat"}, 64'(cyc), 64'(x.lat));
    chk({tag, " hi"}, 64'(hi), 64'(x.hi));
    chk({tag, " lo"}, 64'(lo), 64'(x.lo));
    chk({tag, " dz"}, 64'(div_zero), 64'(x.dz));
    @(negedge clk);
    chk({tag, " idle"}, {62'd0, busy, done}, 64'd0);
  endtask

  exp_t e;
  logic [W-1:0] ra, rb;
  mdu_op_t ro;

  initial begin
    rst = 1; start = 0; op = MDU_MULTU;
    opa = '0; opb = '0; hi_we = 0; lo_we = 0;
    @(negedge clk);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst dz", 64'(div_zero), 64'd0);
    chk("rst hilo", {hi, lo}, 64'd0);
    rst = 0;
    @(negedge clk);

    e = '{hi: 32'hFFFF_FFFE, lo: 32'h1, dz: 0, lat: 34};
    run_op("multu max", MDU_MULTU, '1, '1, e, 0);
    e = '{hi: '1, lo: 32'hFFFF_FFEB, dz: 0, lat: 34};
    run_op("mult -3*7", MDU_MULT, -32'sd3, 32'd7, e, 0);
    e = '{hi: '1, lo: 32'hFFFF_FFFD, dz: 0, lat: 34};
    run_op("div -7/2", MDU_DIV, -32'sd7, 32'd2, e, 0);
    e = '{hi: 32'd100, lo: '1, dz: 1, lat: 1};
    run_op("divu 100/0", MDU_DIVU, 32'd100, 32'd0, e, 0);
    e = '{hi: 32'd2, lo: 32'd14, dz: 0, lat: 34};
    run_op("divu 100/7", MDU_DIVU, 32'd100, 32'd7, e, 0);
    e = '{hi: 32'd0, lo: 32'h8000_0000, dz: 0, lat: 34};
    run_op("div ovf", MDU_DIV, 32'h8000_0000, '1, e, 0);

    e = '{hi: 32'd0, lo: 32'd391, dz: 0, lat: 34};
    run_op("busy ign", MDU_MULTU, 32'd17, 32'd23, e, 1);
    opa = 32'h1234; hi_we = 1;
    @(negedge clk);
    hi_we = 0;
    chk("mthi hi", 64'(hi), 64'h1234);
    chk("mthi lo", 64'(lo), 64'd391);
    opa = 32'h5555; lo_we = 1; start = 1;
    op = MDU_MULTU; opb = 32'd1;
    @(negedge clk);
    lo_we = 0; start = 0;
    chk("mtlo+start lo", 64'(lo), 64'd391);
    for (int i = 0; i < 40 && busy; i++)
      @(negedge clk);
    chk("drain", 64'(busy), 64'd0);

    for (int i = 0; i < 4; i++) begin
      ro = mdu_op_t'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : $urandom;
      run_op("rand", ro, ra, rb, model(ro, ra, rb), 0);
    end

    start = 1; op = MDU_MULTU;
    opa = 32'h1234; opb = 32'h5678;
    @(negedge clk);
    start = 0;
    repeat (9) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("mid rst busy", 64'(busy), 64'd0);
    chk("mid rst done", 64'(done), 64'd0);
    chk("mid rst hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    e = '{hi: 32'd0, lo: 32'd42, dz: 0, lat: 34};
    run_op("multu 6*7", MDU_MULTU, 32'd6, 32'd7, e, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
